// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the pattern-detector bench that consumes its stream.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int   SER_DEFAULT_WIDTH = 8;
  localparam logic SER_IDLE_BIT      = 1'b0;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word handshake into the serializer: producer is master, serializer is slave.
interface bit_serializer_if
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage: one bit per clock, back-to-back words with no gap cycle.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  bit_serializer_if.slave        in_if,
  output logic                   ser_out,
  output logic                   ser_valid,
  output logic                   ser_last,
  output logic                   busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  ser_state_t       state_reg;
  ser_state_t       state_next;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic             ser_out_reg;
  logic             ser_valid_reg;
  logic             ser_last_reg;
  logic             at_last;
  logic             accept;
  logic             in_ready_int;

  // Bit presented next, and the word with that bit consumed.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (at_last && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    at_last      = (state_reg == SHIFT) && (bit_cnt_reg == LAST_IDX);
    in_ready_int = !rst && ((state_reg == IDLE) || at_last);
    accept       = in_if.in_valid && in_ready_int;
    busy         = (state_reg == SHIFT);
  end

  assign in_if.in_ready = in_ready_int;

  // An accept on the last-bit cycle reloads directly, so the stream never gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      ser_out_reg   <= IDLE_BIT;
      ser_valid_reg <= 1'b0;
      ser_last_reg  <= 1'b0;
    end else if (accept) begin
      shift_reg     <= drop_head(in_if.in_data);
      ser_out_reg   <= head_bit(in_if.in_data);
      bit_cnt_reg   <= '0;
      ser_valid_reg <= 1'b1;
      ser_last_reg  <= 1'b0;
    end else if (state_reg == SHIFT && !at_last) begin
      shift_reg     <= drop_head(shift_reg);
      ser_out_reg   <= head_bit(shift_reg);
      bit_cnt_reg   <= bit_cnt_reg + CW'(1);
      ser_valid_reg <= 1'b1;
      ser_last_reg  <= (bit_cnt_reg + CW'(1)) == LAST_IDX;
    end else if (state_reg == SHIFT) begin
      ser_out_reg   <= IDLE_BIT;
      ser_valid_reg <= 1'b0;
      ser_last_reg  <= 1'b0;
    end
  end

  assign ser_out   = ser_out_reg;
  assign ser_valid = ser_valid_reg;
  assign ser_last  = ser_last_reg;

endmodule
